// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic phase controller: 1 Hz prescaler, 8-phase FSM, per-road
// seconds-remaining countdowns, display state codes and one-hot lamp drives.
module traffic_phase_ctrl #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int T_GREEN  = 30,
  parameter int T_LEFT   = 15,
  parameter int T_YELLOW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  output logic [6:0] Acountdown,
  output logic [6:0] Bcountdown,
  output logic [3:0] Astate,
  output logic [3:0] Bstate,
  output logic [3:0] a_lamp,
  output logic [3:0] b_lamp,
  output logic [2:0] phase_dbg
);

  localparam int R_SUM = T_GREEN + T_LEFT + 2 * T_YELLOW;
  localparam int PW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  if (CLK_HZ < 1 || T_GREEN < 1 || T_LEFT < 1 || T_YELLOW < 1 || R_SUM > 99) begin : g_param_err
    $error("traffic_phase_ctrl: durations must be >= 1 and the full red time <= 99");
  end

  localparam logic [6:0]    TG   = 7'(T_GREEN);
  localparam logic [6:0]    TL   = 7'(T_LEFT);
  localparam logic [6:0]    TY   = 7'(T_YELLOW);
  localparam logic [6:0]    TR   = 7'(R_SUM);
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);

  // Encoding order matches the phase cycle; bit 2 clear means road A is active.
  typedef enum logic [2:0] {AG, AY1, AL, AY2, BG, BY1, BL, BY2} phase_t;

  localparam logic [3:0] L_LEFT   = 4'b1000;
  localparam logic [3:0] L_GREEN  = 4'b0100;
  localparam logic [3:0] L_YELLOW = 4'b0010;
  localparam logic [3:0] L_RED    = 4'b0001;

  phase_t        phase_q, phase_d, phase_inc;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    acnt_q, acnt_d, bcnt_q, bcnt_d;
  logic [3:0]    astate_q, astate_d, bstate_q, bstate_d;
  logic [3:0]    alamp_q, alamp_d, blamp_q, blamp_d;
  logic          tick;

  function automatic logic [6:0] dur(input phase_t p);
    case (p)
      AG, BG:  dur = TG;
      AL, BL:  dur = TL;
      default: dur = TY;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q  <= AG;
      presc_q  <= '0;
      acnt_q   <= TG;
      bcnt_q   <= TR;
      astate_q <= 4'd3;
      bstate_q <= 4'd1;
      alamp_q  <= L_GREEN;
      blamp_q  <= L_RED;
    end else begin
      phase_q  <= phase_d;
      presc_q  <= presc_d;
      acnt_q   <= acnt_d;
      bcnt_q   <= bcnt_d;
      astate_q <= astate_d;
      bstate_q <= bstate_d;
      alamp_q  <= alamp_d;
      blamp_q  <= blamp_d;
    end
  end

  assign tick      = !hold && (presc_q == PMAX);
  assign phase_inc = phase_t'(3'(phase_q + 3'd1));

  // Next-state: prescaler, phase advance and both countdowns move together on a tick.
  always_comb begin
    phase_d = phase_q;
    presc_d = presc_q;
    acnt_d  = acnt_q;
    bcnt_d  = bcnt_q;
    if (!hold) begin
      if (tick) begin
        presc_d = '0;
        if (!phase_q[2]) begin
          if (acnt_q == 7'd1) begin
            phase_d = phase_inc;
            acnt_d  = (phase_q == AY2) ? TR : dur(phase_inc);
            bcnt_d  = (phase_q == AY2) ? TG : bcnt_q - 7'd1;
          end else begin
            acnt_d = acnt_q - 7'd1;
            bcnt_d = bcnt_q - 7'd1;
          end
        end else begin
          if (bcnt_q == 7'd1) begin
            phase_d = phase_inc;
            bcnt_d  = (phase_q == BY2) ? TR : dur(phase_inc);
            acnt_d  = (phase_q == BY2) ? TG : acnt_q - 7'd1;
          end else begin
            acnt_d = acnt_q - 7'd1;
            bcnt_d = bcnt_q - 7'd1;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Display codes and lamps are decoded from the next phase so they register
  // on the same edge as the phase itself.
  always_comb begin
    astate_d = 4'd0;
    bstate_d = 4'd1;
    alamp_d  = L_RED;
    blamp_d  = L_RED;
    case (phase_d)
      AG:  begin astate_d = 4'd3; alamp_d = L_GREEN;  end
      AY1: begin astate_d = 4'd2; alamp_d = L_YELLOW; end
      AL:  begin astate_d = 4'd1; alamp_d = L_LEFT;   end
      AY2: begin astate_d = 4'd4; alamp_d = L_YELLOW; end
      BG:  begin bstate_d = 4'd4; blamp_d = L_GREEN;  end
      BY1: begin bstate_d = 4'd3; blamp_d = L_YELLOW; end
      BL:  begin bstate_d = 4'd2; blamp_d = L_LEFT;   end
      BY2: begin bstate_d = 4'd0; blamp_d = L_YELLOW; end
      default: begin astate_d = 4'd0; bstate_d = 4'd1; end
    endcase
  end

  assign Acountdown = acnt_q;
  assign Bcountdown = bcnt_q;
  assign Astate     = astate_q;
  assign Bstate     = bstate_q;
  assign a_lamp     = alamp_q;
  assign b_lamp     = blamp_q;
  assign phase_dbg  = phase_q;

endmodule
